// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module  : fetch_ctrl_pkg
// Brief   : Shared state encoding and address constants for the fetch controller.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI    = 32'h0000_6FFC;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_addr_chk.sv
// ============================================================================
// Module  : fetch_addr_chk
// Brief   : Combinational fetch address check (alignment and IM window).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_addr_chk
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] IM_LO = DEF_IM_LO,
    parameter logic [31:0] IM_HI = DEF_IM_HI
) (
    input  logic [31:0] pc_i,
    output logic        fetch_adel_o
);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = |pc_i[1:0];
    assign w_out_of_range = (pc_i < IM_LO) || (pc_i > IM_HI);
    assign fetch_adel_o   = w_misaligned || w_out_of_range;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module  : fetch_ctrl
// Brief   : Next-PC sequencing: exception/ERET entry, branch redirects held
//           across stalls, and sequential fetch.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
    parameter logic [31:0] IM_LO    = DEF_IM_LO,
    parameter logic [31:0] IM_HI    = DEF_IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_i,
    output logic [31:0] npc_o,
    output logic        pc_we,
    output logic        flush_o,
    output logic        fetch_adel,
    output logic        pend_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;
    logic         flush_q, flush_d;

    logic [31:0]  w_npc;
    logic         w_pc_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            pend_tgt_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_tgt_q <= pend_tgt_d;
            flush_q    <= flush_d;
        end
    end

    // Priority: exception > ERET > branch > held redirect > sequential.
    always_comb begin
        state_d    = ST_RUN;
        pend_tgt_d = pend_tgt_q;
        flush_d    = 1'b0;
        w_npc      = pc_i + PC_STEP;
        w_pc_we    = ~stall_i;

        if (exc_req) begin
            w_npc      = EXC_PC;
            w_pc_we    = 1'b1;
            pend_tgt_d = '0;
            flush_d    = 1'b1;
            state_d    = ST_REDIR;
        end else if (eret_req) begin
            w_npc      = epc_i;
            w_pc_we    = 1'b1;
            pend_tgt_d = '0;
            flush_d    = 1'b1;
            state_d    = ST_REDIR;
        end else if (br_valid && stall_i) begin
            w_npc      = br_target;
            w_pc_we    = 1'b0;
            pend_tgt_d = br_target;
            state_d    = ST_HOLD;
        end else if (br_valid) begin
            w_npc      = br_target;
            w_pc_we    = 1'b1;
            pend_tgt_d = '0;
            state_d    = ST_RUN;
        end else if (state_q == ST_HOLD) begin
            w_npc      = pend_tgt_q;
            w_pc_we    = ~stall_i;
            state_d    = stall_i ? ST_HOLD : ST_RUN;
        end
    end

    // Reset must hold the IFU at RESET_PC even between clock edges.
    assign npc_o   = reset ? w_npc : RESET_PC;
    assign pc_we   = reset & w_pc_we;
    assign flush_o = flush_q;
    assign pend_o  = (state_q == ST_HOLD);

    fetch_addr_chk #(
        .IM_LO (IM_LO),
        .IM_HI (IM_HI)
    ) u_addr_chk (
        .pc_i         (pc_i),
        .fetch_adel_o (fetch_adel)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module  : tb_fetch_ctrl
// Brief   : Self-checking bench for fetch_ctrl (vector table plus scoreboard).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        brv;
        logic [31:0] brt;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        chk_npc;
        logic [31:0] npc;
        logic        we;
        logic        flush;
        logic        adel;
        logic        pend;
    } vec_t;

    typedef struct {
        logic        chk_npc;
        logic [31:0] npc;
        logic        we;
        logic        flush;
        logic        adel;
        logic        pend;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc_i;
    logic [31:0] npc_o;
    logic        pc_we;
    logic        flush_o;
    logic        fetch_adel;
    logic        pend_o;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];
    exp_t sb[$];

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pc_i       (pc_i),
        .stall_i    (stall_i),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc_i      (epc_i),
        .npc_o      (npc_o),
        .pc_we      (pc_we),
        .flush_o    (flush_o),
        .fetch_adel (fetch_adel),
        .pend_o     (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst_n, logic stall, logic brv, logic [31:0] brt,
                                logic exc, logic eret, logic [31:0] epc, logic [31:0] pc,
                                logic chk_npc, logic [31:0] npc, logic we, logic flush,
                                logic adel, logic pend);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.brv = brv; v.brt = brt;
        v.exc = exc; v.eret = eret; v.epc = epc; v.pc = pc;
        v.chk_npc = chk_npc; v.npc = npc; v.we = we; v.flush = flush;
        v.adel = adel; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_push(input vec_t v);
        exp_t e;
        reset     = v.rst_n;
        stall_i   = v.stall;
        br_valid  = v.brv;
        br_target = v.brt;
        exc_req   = v.exc;
        eret_req  = v.eret;
        epc_i     = v.epc;
        pc_i      = v.pc;
        e.chk_npc = v.chk_npc; e.npc = v.npc; e.we = v.we;
        e.flush = v.flush; e.adel = v.adel; e.pend = v.pend;
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (e.chk_npc) chk({tag, " npc_o"}, npc_o, e.npc);
            chk({tag, " pc_we"},      {31'd0, pc_we},      {31'd0, e.we});
            chk({tag, " flush_o"},    {31'd0, flush_o},    {31'd0, e.flush});
            chk({tag, " fetch_adel"}, {31'd0, fetch_adel}, {31'd0, e.adel});
            chk({tag, " pend_o"},     {31'd0, pend_o},     {31'd0, e.pend});
        end
    endtask

    initial begin
        reset = 1'b0; stall_i = 1'b0; br_valid = 1'b0; br_target = '0;
        exc_req = 1'b0; eret_req = 1'b0; epc_i = '0; pc_i = 32'h3000;

        //             rst st br brt          ex er epc          pc           cn npc          we fl ad pd
        vecs.push_back(mk(0, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3000,     1, 32'h3000,     0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3000,     1, 32'h3004,     1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h3100,  0, 0, 32'h0,     32'h3010,     0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,     0, 0, 32'h0,     32'h3010,     1, 32'h3100,     0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0,     0, 0, 32'h0,     32'h3010,     1, 32'h3100,     0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3010,     1, 32'h3100,     1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3100,     1, 32'h3104,     1, 0, 0, 0));
        // Newer branch overwrites the held target.
        vecs.push_back(mk(1, 1, 1, 32'h3100,  0, 0, 32'h0,     32'h3104,     0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h3200,  0, 0, 32'h0,     32'h3104,     0, 32'h0,        0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0,     0, 0, 32'h0,     32'h3104,     1, 32'h3200,     0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3104,     1, 32'h3200,     1, 0, 0, 1));
        // Exception beats ERET and stall, discarding the held redirect.
        vecs.push_back(mk(1, 1, 1, 32'h3300,  0, 0, 32'h0,     32'h3200,     0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,     1, 1, 32'h3050,  32'h3200,     1, 32'h4180,     1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h4180,     1, 32'h4184,     1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h4184,     1, 32'h4188,     1, 0, 0, 0));
        // ERET, then address-error boundaries.
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 1, 32'h3058,  32'h4188,     1, 32'h3058,     1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3058,     1, 32'h305C,     1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3002,     1, 32'h3006,     1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h7000,     1, 32'h7004,     1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h6FFC,     1, 32'h7000,     1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h2FFC,     1, 32'h3000,     1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'hFFFF_FFFC, 1, 32'h0,       1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,     0, 0, 32'h0,     32'h3000,     1, 32'h3004,     0, 0, 0, 0));
        // Stalled branch landing inside the REDIR cycle.
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 1, 32'h3000,  32'h3000,     1, 32'h3000,     1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h3400,  0, 0, 32'h0,     32'h3000,     0, 32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3000,     1, 32'h3400,     1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3400,     1, 32'h3404,     1, 0, 0, 0));
        // Unstalled branch in HOLD replaces the held target.
        vecs.push_back(mk(1, 1, 1, 32'h3500,  0, 0, 32'h0,     32'h3404,     0, 32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h3600,  0, 0, 32'h0,     32'h3404,     1, 32'h3600,     1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,     0, 0, 32'h0,     32'h3600,     1, 32'h3604,     1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive_push(vecs[i]);
            @(negedge clk);
            pop_compare($sformatf("vec%0d", i));
        end

        // Asynchronous reset arriving mid-HOLD, between clock edges.
        @(posedge clk);
        #1;
        drive_push(mk(1, 1, 1, 32'h3700, 0, 0, 32'h0, 32'h3604, 0, 32'h0, 0, 0, 0, 0));
        @(negedge clk);
        pop_compare("arst_enter");
        @(posedge clk);
        #1;
        drive_push(mk(1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h3604, 1, 32'h3700, 0, 0, 0, 1));
        @(negedge clk);
        pop_compare("arst_hold");
        #2;
        drive_push(mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h3604, 1, 32'h3000, 0, 0, 0, 0));
        #1;
        pop_compare("arst_immediate");
        @(posedge clk);
        #1;
        drive_push(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h3000, 1, 32'h3000, 0, 0, 0, 0));
        @(negedge clk);
        pop_compare("arst_held");
        #2;
        drive_push(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h3000, 1, 32'h3004, 1, 0, 0, 0));
        #1;
        pop_compare("arst_release");
        @(posedge clk);
        #1;
        drive_push(mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h3004, 1, 32'h3008, 1, 0, 0, 0));
        @(negedge clk);
        pop_compare("arst_resume");

        if (sb.size() != 0) chk("scoreboard drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch unit. It owns the decision of what the fetch PC becomes next and when it may change.
- It arbitrates between reset, exception/interrupt entry, ERET return, branch/jump redirects and sequential fetch. It drives the IFU's next-PC and write-enable, and checks the current PC for fetch address errors.
- Sits between the hazard unit, the D-stage branch resolver, CP0 and the IFU.

Parameters:
- RESET_PC, 32'h0000_3000, PC value forced by reset.
- EXC_PC, 32'h0000_4180, exception/interrupt handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low; 0 resets the block.
- pc_i  in  32  current fetch PC from the IFU.
- stall_i  in  1  F/D stall from the hazard unit.
- br_valid  in  1  one-cycle pulse: a taken branch/jump was resolved.
- br_target  in  32  redirect target, valid with br_valid.
- exc_req  in  1  CP0 exception/interrupt entry request.
- eret_req  in  1  ERET executed.
- epc_i  in  32  CP0 EPC, used on ERET.
- npc_o  out  32  next PC to the IFU.
- pc_we  out  1  IFU PC write-enable.
- flush_o  out  1  kill the instruction currently in F (insert NOP into F/D).
- fetch_adel  out  1  fetch address error on pc_i.
- pend_o  out  1  a redirect is latched and waiting for the stall to clear.

Behaviour:
- States: RUN, HOLD, REDIR. Registers: state, pend_tgt[31:0], flush_q.
- Reset (reset=0, asynchronous): state=RUN, pend_tgt=0, flush_q=0. While reset is low: pc_we=0, npc_o=RESET_PC, flush_o=0, pend_o=0.
- Combinational priority, evaluated every cycle out of reset:
  1. exc_req: npc_o=EXC_PC, pc_we=1. Ignores stall_i. Discards any pending redirect. Next state=REDIR.
  2. eret_req: npc_o=epc_i, pc_we=1. Ignores stall_i. Discards any pending redirect. Next state=REDIR.
  3. br_valid with stall_i=1: pc_we=0, pend_tgt<=br_target. Next state=HOLD. A newer br_valid in HOLD overwrites pend_tgt.
  4. br_valid with stall_i=0: npc_o=br_target, pc_we=1. Next state=RUN. Any pending target is discarded because the newer one wins.
  5. HOLD with stall_i=0: npc_o=pend_tgt, pc_we=1. Next state=RUN.
  6. HOLD with stall_i=1: pc_we=0, npc_o=pend_tgt. Stay in HOLD.
  7. Otherwise: npc_o=pc_i+4 (mod 2^32), pc_we=~stall_i.
- REDIR: lasts exactly one cycle. flush_o=1 throughout it (flush_o is registered; it is high in the cycle after the exc/eret edge). Priority rules 1-7 still apply during REDIR. Next state after REDIR follows those rules; the default is RUN.
- exc_req and eret_req both high in the same cycle: exception wins.
- pend_o = (state==HOLD).
- fetch_adel = pc_i[1:0]!=0, or pc_i<IM_LO, or pc_i>IM_HI. It is purely combinational and does not alter npc_o or pc_we; CP0 handles it through exc_req.
- Reset asserted mid-HOLD: pending target is lost and state returns to RUN. First PC after reset is RESET_PC, from the IFU.
- Latency: a redirect is visible on pc_i one cycle after the edge where pc_we=1.

Decomposition:
- Shared package holds: state encoding (RUN, HOLD, REDIR), RESET_PC, EXC_PC, IM_LO, IM_HI constants.
- One natural sub-module: fetch_addr_chk, which is combinational and produces fetch_adel. Everything else stays flat.

Test Plan:
- Reset low, then release; stall_i=0, pc_i=0x3000 -> npc_o=0x3004, pc_we=1; during reset pc_we=0 and npc_o=0x3000.
- pc_i=0x3010, stall_i=1 for 3 cycles, br_valid pulse 0x3100 in the first stalled cycle -> pc_we=0 and pend_o=1 for 3 cycles; when the stall drops, npc_o=0x3100, pc_we=1, pend_o=0.
- HOLD with pend_tgt=0x3100, then a second br_valid 0x3200 while still stalled -> after the stall drops, npc_o=0x3200.
- stall_i=1, exc_req=1, eret_req=1, epc_i=0x3050 in the same cycle -> npc_o=0x4180, pc_we=1, pend_o cleared; next cycle flush_o=1 for exactly one cycle.
- eret_req with epc_i=0x3058, no stall -> npc_o=0x3058, pc_we=1, flush_o=1 next cycle. Then pc_i=0x3002 -> fetch_adel=1; pc_i=0x7000 -> fetch_adel=1; pc_i=0x6FFC -> fetch_adel=0.
- Reset pulsed low asynchronously mid-HOLD (between clock edges) -> pend_o drops to 0 immediately, flush_o=0; after release, normal sequential fetch resumes.
